frac_feeder: RTL

FRAC_FEEDER -- requirements
Module: frac_feeder

---
 rtl/frac_feeder_pkg.sv | 45 ++++
 rtl/frac_feeder_block_row_buffer.sv | 38 +++
 rtl/frac_feeder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/frac_feeder_pkg.sv
// frac_feeder_pkg
//   Shared definitions for the frac_search block feeder: geometry of the
//   8x8 pixel block, result field widths, play/wait phase lengths, the
//   feeder state encoding and the row-buffer slot helpers.
package frac_feeder_pkg;

   localparam int ROWS     = 8;
   localparam int PIX_W    = 8;
   localparam int ROW_W    = ROWS * PIX_W;   // 64
   localparam int SAD_W    = 12;
   localparam int MV_W     = 3;
   localparam int PLAY_LEN = 8;
   localparam int WAIT_LEN = 2;

   // 16 beats per block: 8 cur rows followed by 8 org rows
   localparam int BEATS  = 2 * ROWS;
   localparam int BEAT_W = $clog2(BEATS);
   // play counter runs k = 0 .. PLAY_LEN+WAIT_LEN-1
   localparam int K_W    = $clog2(PLAY_LEN + WAIT_LEN);
   // org pixels presented to frac_search are bits [55:8] of an org row
   localparam int ORG_W  = ROW_W - 2 * PIX_W;

   localparam logic [BEAT_W-1:0] BEAT_LAST   = BEAT_W'(BEATS - 1);
   localparam logic [K_W-1:0]    K_PLAY_LAST = K_W'(PLAY_LEN - 1);
   localparam logic [K_W-1:0]    K_WAIT_LAST = K_W'(PLAY_LEN + WAIT_LEN - 1);
   localparam logic [K_W-1:0]    K_ORG_FIRST = K_W'(2);

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_PLAY = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // buffer slot holding cur row k
   function automatic logic [BEAT_W-1:0] cur_slot(input logic [K_W-1:0] k);
      return BEAT_W'(k);
   endfunction

   // buffer slot holding org row k-1 (org rows live in slots ROWS..BEATS-1)
   function automatic logic [BEAT_W-1:0] org_slot(input logic [K_W-1:0] k);
      return BEAT_W'(ROWS) + BEAT_W'(k) - BEAT_W'(1);
   endfunction

endpackage

// File: rtl/frac_feeder_block_row_buffer.sv
// block_row_buffer
//   16 x 64-bit register file holding one block (cur rows in slots 0-7,
//   org rows in slots 8-15). One synchronous write port, two asynchronous
//   read ports. Contents are deliberately not reset.
// Ports:
//   clk         system clock
//   i_we        write enable (one accepted beat)
//   i_waddr     write slot (beat index)
//   i_wdata     row written
//   i_cur_addr  read slot for the cur row
//   o_cur_row   cur row read data
//   i_org_addr  read slot for the org row
//   o_org_row   org row read data
module block_row_buffer
   import frac_feeder_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [BEAT_W-1:0] i_waddr,
   input  logic [ROW_W-1:0]  i_wdata,
   input  logic [BEAT_W-1:0] i_cur_addr,
   output logic [ROW_W-1:0]  o_cur_row,
   input  logic [BEAT_W-1:0] i_org_addr,
   output logic [ROW_W-1:0]  o_org_row
);

   logic [ROW_W-1:0] r_mem [BEATS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_cur_row = r_mem[i_cur_addr];
   assign o_org_row = r_mem[i_org_addr];

endmodule

// File: rtl/frac_feeder.sv
// frac_feeder
//   Collects one 8x8 block (8 cur rows + 8 org rows) from an upstream
//   valid/ready row stream, replays it to frac_search over 8 cycles, waits
//   out the 2-cycle search/accumulate tail, captures the SAD and QPEL
//   vector and holds them on a valid/ready result port.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data   upstream row beats (pixel 0 in [7:0])
//   fs_ready                    frac_search ready (high for the 8 play cycles)
//   fs_cur_pix                  cur row k during play, else 0
//   fs_org_pix                  org row k-1 bits [55:8] for k>=2, else 0
//   fs_sad, fs_mvx, fs_mvy      frac_search result inputs
//   res_valid/res_ready         result handshake
//   res_sad, res_mvx, res_mvy   captured result
module frac_feeder
   import frac_feeder_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [ROW_W-1:0] in_data,
   output logic             fs_ready,
   output logic [ROW_W-1:0] fs_cur_pix,
   output logic [ORG_W-1:0] fs_org_pix,
   input  logic [SAD_W-1:0] fs_sad,
   input  logic [MV_W-1:0]  fs_mvx,
   input  logic [MV_W-1:0]  fs_mvy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SAD_W-1:0] res_sad,
   output logic [MV_W-1:0]  res_mvx,
   output logic [MV_W-1:0]  res_mvy
);

   state_t            r_state;
   logic [BEAT_W-1:0] r_beat;
   logic [K_W-1:0]    r_k;
   logic              r_in_ready;
   logic              r_fs_ready;
   logic              r_res_valid;
   logic [SAD_W-1:0]  r_res_sad;
   logic [MV_W-1:0]   r_res_mvx;
   logic [MV_W-1:0]   r_res_mvy;

   logic              w_accept;
   logic [ROW_W-1:0]  w_cur_row;
   logic [ROW_W-1:0]  w_org_row;
   logic              w_unused_org;

   // r_in_ready mirrors "state == LOAD", so only LOAD can accept beats
   assign w_accept = in_valid && r_in_ready;

   block_row_buffer u_buf (
      .clk        (clk),
      .i_we       (w_accept),
      .i_waddr    (r_beat),
      .i_wdata    (in_data),
      .i_cur_addr (cur_slot(r_k)),
      .o_cur_row  (w_cur_row),
      .i_org_addr (org_slot(r_k)),
      .o_org_row  (w_org_row)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_LOAD;
         r_beat      <= '0;
         r_k         <= '0;
         r_in_ready  <= 1'b1;
         r_fs_ready  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_sad   <= '0;
         r_res_mvx   <= '0;
         r_res_mvy   <= '0;
      end else begin
         unique case (r_state)
            ST_LOAD: begin
               if (w_accept) begin
                  r_beat <= r_beat + 1'b1;
                  if (r_beat == BEAT_LAST) begin
                     r_state    <= ST_PLAY;
                     r_in_ready <= 1'b0;
                     r_fs_ready <= 1'b1;
                     r_k        <= '0;
                  end
               end
            end
            ST_PLAY: begin
               r_k <= r_k + 1'b1;
               if (r_k == K_PLAY_LAST) begin
                  r_state    <= ST_WAIT;
                  r_fs_ready <= 1'b0;
               end
            end
            ST_WAIT: begin
               r_k <= r_k + 1'b1;
               // frac_search result is valid on the last wait cycle
               if (r_k == K_WAIT_LAST) begin
                  r_state     <= ST_DONE;
                  r_k         <= '0;
                  r_res_valid <= 1'b1;
                  r_res_sad   <= fs_sad;
                  r_res_mvx   <= fs_mvx;
                  r_res_mvy   <= fs_mvy;
               end
            end
            ST_DONE: begin
               if (res_ready) begin
                  r_state     <= ST_LOAD;
                  r_beat      <= '0;
                  r_in_ready  <= 1'b1;
                  r_res_valid <= 1'b0;
               end
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign fs_ready   = r_fs_ready;
   assign fs_cur_pix = r_fs_ready ? w_cur_row : '0;
   // org row k-1 only exists from k=2 on; earlier play cycles present zero
   assign fs_org_pix = (r_fs_ready && (r_k >= K_ORG_FIRST))
                       ? w_org_row[ROW_W-PIX_W-1:PIX_W] : '0;
   assign w_unused_org = ^{w_org_row[ROW_W-1:ROW_W-PIX_W], w_org_row[PIX_W-1:0]};

   assign res_valid = r_res_valid;
   assign res_sad   = r_res_sad;
   assign res_mvx   = r_res_mvx;
   assign res_mvy   = r_res_mvy;

endmodule
